// File: rtl/rr_mux_pkg.sv
// Shared types and helpers for the round-robin register mux (rr_mux_reg).
// Build option RR_MUX_FIXED_PRIO_EN is consumed by rr_arbiter and rr_mux_reg.
package rr_mux_pkg;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

  // Channel index width; a single channel still needs a 1-bit index.
  function automatic int clog2_min1(input int n);
    if (n > 1) begin
      return $clog2(n);
    end else begin
      return 1;
    end
  endfunction

endpackage

// File: rtl/rr_mux_reg_if.sv
// Handshake bundle for rr_mux_reg: N request channels in, one registered word out.
// master = the side driving requests and out_ready; slave = the mux itself.
interface rr_mux_reg_if #(
  parameter int N     = 4,
  parameter int WIDTH = 32
);
  import rr_mux_pkg::*;

  localparam int SELW = clog2_min1(N);

  logic [N-1:0]       in_valid;
  logic [N*WIDTH-1:0] in_data;
  logic [N-1:0]       in_ready;
  logic               out_valid;
  logic [WIDTH-1:0]   out_data;
  logic [SELW-1:0]    out_sel;
  logic               out_ready;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_sel
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_sel
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational request arbiter: round-robin from ptr, or fixed lowest-index
// priority when RR_MUX_FIXED_PRIO_EN is defined (ptr then ignored).
module rr_arbiter
  import rr_mux_pkg::*;
#(
  parameter int N    = 4,
  parameter int SELW = clog2_min1(N)
) (
  input  logic [N-1:0]    req,
  input  logic [SELW-1:0] ptr,
  output logic [N-1:0]    grant_onehot,
  output logic [SELW-1:0] grant_idx,
  output logic            any
);

  localparam logic [SELW:0] N_W = (SELW+1)'(N);

  logic [SELW:0]   base_s;
  logic [SELW:0]   idx_s;
  logic [SELW-1:0] idx_sel_s;
  logic            found_s;

`ifdef RR_MUX_FIXED_PRIO_EN
  assign base_s = {1'b0, ptr & {SELW{1'b0}}};
`else
  assign base_s = {1'b0, ptr};
`endif

  // Scan base, base+1, ... wrapping at N (not at 2**SELW); first requester wins
  always_comb begin
    grant_onehot = {N{1'b0}};
    grant_idx    = {SELW{1'b0}};
    found_s      = 1'b0;
    idx_s        = {(SELW+1){1'b0}};
    idx_sel_s    = {SELW{1'b0}};
    for (int k = 0; k < N; k++) begin
      idx_s = base_s + (SELW+1)'(k);
      if (idx_s >= N_W) begin
        idx_s = idx_s - N_W;
      end else begin
        idx_s = idx_s;
      end
      idx_sel_s = idx_s[SELW-1:0];
      if (!found_s && req[idx_sel_s]) begin
        found_s                 = 1'b1;
        grant_idx               = idx_sel_s;
        grant_onehot[idx_sel_s] = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end

  assign any = found_s;

endmodule

// File: rtl/rr_mux_reg_chk.sv
// Protocol checker for rr_mux_reg: at most one in_ready, out_sel always a real channel.
module rr_mux_reg_chk #(
  parameter int N    = 4,
  parameter int SELW = 2
) (
  input logic            clk,
  input logic            rst,
  input logic [N-1:0]    in_ready,
  input logic            out_valid,
  input logic [SELW-1:0] out_sel
);

  localparam logic [SELW:0] N_W = (SELW+1)'(N);

  a_ready_onehot0: assert property (@(posedge clk) disable iff (rst) $onehot0(in_ready));

  a_sel_in_range: assert property (@(posedge clk) disable iff (rst)
    out_valid |-> ({1'b0, out_sel} < N_W));

endmodule

// File: rtl/rr_mux_reg.sv
// N-input round-robin mux with one registered output stage and winner index.
// Define RR_MUX_FIXED_PRIO_EN for fixed lowest-index priority (ptr held at 0).
module rr_mux_reg
  import rr_mux_pkg::*;
#(
  parameter int N     = 4,
  parameter int WIDTH = 32
) (
  input  logic        clk,
  input  logic        rst,
  rr_mux_reg_if.slave bus
);

  localparam int              SELW     = clog2_min1(N);
  localparam logic [SELW-1:0] LAST_IDX = SELW'(N-1);

  state_e           state_r;
  logic [WIDTH-1:0] data_r;
  logic [SELW-1:0]  sel_r;
  logic [SELW-1:0]  ptr_r;

  logic [N-1:0]     grant_onehot_s;
  logic [N-1:0]     ready_s;
  logic [SELW-1:0]  grant_idx_s;
  logic [SELW-1:0]  ptr_next_s;
  logic [WIDTH-1:0] sel_data_s;
  logic             any_s;
  logic             can_load_s;
  logic             xfer_s;

  rr_arbiter #(
    .N    (N),
    .SELW (SELW)
  ) u_arb (
    .req          (bus.in_valid),
    .ptr          (ptr_r),
    .grant_onehot (grant_onehot_s),
    .grant_idx    (grant_idx_s),
    .any          (any_s)
  );

  // Offer the slot to the granted channel only when the register can take a word
  always_comb begin
    can_load_s = (state_r == ST_EMPTY) || bus.out_ready;
    xfer_s     = 1'b0;
    ready_s    = {N{1'b0}};
    if (!rst && can_load_s && any_s) begin
      xfer_s  = 1'b1;
      ready_s = grant_onehot_s;
    end else begin
      xfer_s  = 1'b0;
      ready_s = {N{1'b0}};
    end
  end

  // AND-OR data select keyed by the one-hot grant
  always_comb begin
    sel_data_s = {WIDTH{1'b0}};
    for (int i = 0; i < N; i++) begin
      sel_data_s = sel_data_s | ({WIDTH{grant_onehot_s[i]}} & bus.in_data[i*WIDTH +: WIDTH]);
    end
  end

`ifdef RR_MUX_FIXED_PRIO_EN
  assign ptr_next_s = {SELW{1'b0}};
`else
  assign ptr_next_s = (grant_idx_s == LAST_IDX) ? {SELW{1'b0}} : grant_idx_s + SELW'(1);
`endif

  // Output-stage FSM: load on transfer, drain on out_ready, hold otherwise
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_EMPTY;
      data_r  <= {WIDTH{1'b0}};
      sel_r   <= {SELW{1'b0}};
      ptr_r   <= {SELW{1'b0}};
    end else if (xfer_s) begin
      state_r <= ST_FULL;
      data_r  <= sel_data_s;
      sel_r   <= grant_idx_s;
      ptr_r   <= ptr_next_s;
    end else begin
      case (state_r)
        ST_FULL:  state_r <= bus.out_ready ? ST_EMPTY : ST_FULL;
        ST_EMPTY: state_r <= ST_EMPTY;
        default:  state_r <= ST_EMPTY;
      endcase
    end
  end

  assign bus.in_ready  = ready_s;
  assign bus.out_valid = (state_r == ST_FULL);
  assign bus.out_data  = data_r;
  assign bus.out_sel   = sel_r;

endmodule

// File: tb/tb_rr_mux_reg.sv
// Randomised + directed bench for rr_mux_reg (N=4 and N=3 instances) against a
// modular-arithmetic reference model. Honours RR_MUX_FIXED_PRIO_EN.
module tb_rr_mux_reg;

  localparam int W = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rr_mux_reg_if #(.N(4), .WIDTH(W)) bus4 ();
  rr_mux_reg_if #(.N(3), .WIDTH(W)) bus3 ();

  rr_mux_reg #(.N(4), .WIDTH(W)) dut4 (.clk(clk), .rst(rst), .bus(bus4));
  rr_mux_reg #(.N(3), .WIDTH(W)) dut3 (.clk(clk), .rst(rst), .bus(bus3));

  rr_mux_reg_chk #(.N(4), .SELW(2)) chk4 (.clk(clk), .rst(rst), .in_ready(bus4.in_ready),
                                          .out_valid(bus4.out_valid), .out_sel(bus4.out_sel));
  rr_mux_reg_chk #(.N(3), .SELW(2)) chk3 (.clk(clk), .rst(rst), .in_ready(bus3.in_ready),
                                          .out_valid(bus3.out_valid), .out_sel(bus3.out_sel));

  // stimulus staging, applied just after each rising edge
  logic         rst_v;
  logic [3:0]   v4;
  logic [127:0] d4;
  logic         or4;
  logic [2:0]   v3;
  logic [95:0]  d3;
  logic         or3;

  int n_chk  = 0;
  int n_fail = 0;

  // reference model state, index 0 = N4 instance, 1 = N3 instance
  int          m_ptr   [2];
  logic        m_valid [2];
  logic [31:0] m_data  [2];
  int          m_sel   [2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int grant(input int n, input int ptr, input logic [3:0] req);
    int base;
    base = ptr;
`ifdef RR_MUX_FIXED_PRIO_EN
    base = 0;
`endif
    for (int k = 0; k < n; k++) begin
      if (req[(base + k) % n]) return (base + k) % n;
    end
    return -1;
  endfunction

  task automatic model_step(input int u, input int n, input logic [3:0] req,
                            input logic [127:0] data, input logic ordy,
                            input logic [3:0] rdy_obs, input logic ov,
                            input logic [31:0] od, input logic [31:0] os);
    int         g;
    logic       can;
    logic [3:0] exp_rdy;
    g       = grant(n, m_ptr[u], req);
    can     = !m_valid[u] || ordy;
    exp_rdy = (!rst && can && g >= 0) ? 4'(1 << g) : 4'b0000;
    chk($sformatf("in_ready_n%0d", n),  {28'd0, rdy_obs}, {28'd0, exp_rdy});
    chk($sformatf("out_valid_n%0d", n), {31'd0, ov}, {31'd0, m_valid[u]});
    chk($sformatf("out_data_n%0d", n),  od, m_data[u]);
    chk($sformatf("out_sel_n%0d", n),   os, 32'(m_sel[u]));
    if (rst) begin
      m_valid[u] = 1'b0; m_data[u] = 32'd0; m_sel[u] = 0; m_ptr[u] = 0;
    end else if (can && g >= 0) begin
      m_valid[u] = 1'b1;
      m_data[u]  = data[g*32 +: 32];
      m_sel[u]   = g;
      m_ptr[u]   = (g + 1) % n;
    end else if (m_valid[u] && ordy) begin
      m_valid[u] = 1'b0;
    end
  endtask

  task automatic apply();
    rst            = rst_v;
    bus4.in_valid  = v4;
    bus4.in_data   = d4;
    bus4.out_ready = or4;
    bus3.in_valid  = v3;
    bus3.in_data   = d3;
    bus3.out_ready = or3;
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
    apply();
    @(negedge clk);
    model_step(0, 4, v4, d4, or4, bus4.in_ready, bus4.out_valid, bus4.out_data, 32'(bus4.out_sel));
    model_step(1, 3, {1'b0, v3}, {32'd0, d3}, or3, {1'b0, bus3.in_ready}, bus3.out_valid,
               bus3.out_data, 32'(bus3.out_sel));
  endtask

  task automatic seq_data4(input logic [31:0] base);
    for (int i = 0; i < 4; i++) d4[i*32 +: 32] = base + 32'(i);
  endtask

  int exp_sel;
  int wrap_exp [3];

  initial begin
    for (int u = 0; u < 2; u++) begin
      m_ptr[u] = 0; m_valid[u] = 1'b0; m_data[u] = 32'd0; m_sel[u] = 0;
    end
    rst_v = 1'b1; v4 = 4'hF; d4 = 128'd0; or4 = 1'b1; v3 = 3'b111; d3 = 96'd0; or3 = 1'b1;
    apply();

    // reset held with everything requesting
    cycle();
    cycle();
    chk("reset_rdy4", {28'd0, bus4.in_ready}, 32'd0);

    // single channel
    rst_v = 1'b0; v4 = 4'b0100; d4 = 128'd0; d4[2*32 +: 32] = 32'hA5A5_0002; v3 = 3'b000;
    cycle();
    chk("single_rdy", {28'd0, bus4.in_ready}, 32'h4);
    v4 = 4'b0000;
    cycle();
    chk("single_data", bus4.out_data, 32'hA5A5_0002);
    chk("single_sel", 32'(bus4.out_sel), 32'd2);

    // rotation with all four valid
    rst_v = 1'b1; cycle();
    rst_v = 1'b0; v4 = 4'hF; seq_data4(32'h10); or4 = 1'b1;
    for (int k = 0; k < 9; k++) begin
      cycle();
      if (k >= 1) begin
`ifdef RR_MUX_FIXED_PRIO_EN
        exp_sel = 0;
`else
        exp_sel = (k - 1) % 4;
`endif
        chk("rot_sel", 32'(bus4.out_sel), 32'(exp_sel));
        chk("rot_data", bus4.out_data, 32'h10 + 32'(exp_sel));
      end
    end

    // backpressure: hold sel=1 while 0 and 3 request, then release
    rst_v = 1'b1; cycle();
    rst_v = 1'b0; v4 = 4'b0010; seq_data4(32'h20); or4 = 1'b1;
    cycle();
    v4 = 4'b1001; or4 = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cycle();
      chk("bp_sel", 32'(bus4.out_sel), 32'd1);
      chk("bp_data", bus4.out_data, 32'h21);
      chk("bp_rdy", {28'd0, bus4.in_ready}, 32'd0);
    end
    or4 = 1'b1;
    cycle();
    v4 = 4'b0000;
    cycle();
`ifdef RR_MUX_FIXED_PRIO_EN
    chk("bp_next_sel", 32'(bus4.out_sel), 32'd0);
`else
    chk("bp_next_sel", 32'(bus4.out_sel), 32'd3);
`endif

    // non-power-of-2 wrap on the N=3 instance
`ifdef RR_MUX_FIXED_PRIO_EN
    wrap_exp = '{1, 1, 0};
`else
    wrap_exp = '{1, 2, 0};
`endif
    rst_v = 1'b1; cycle();
    rst_v = 1'b0; v3 = 3'b110; or3 = 1'b1;
    d3 = {32'h32, 32'h31, 32'h30};
    cycle();
    cycle();
    chk("wrap_sel0", 32'(bus3.out_sel), 32'(wrap_exp[0]));
    v3 = 3'b111;
    cycle();
    chk("wrap_sel1", 32'(bus3.out_sel), 32'(wrap_exp[1]));
    v3 = 3'b000;
    cycle();
    chk("wrap_sel2", 32'(bus3.out_sel), 32'(wrap_exp[2]));

    // reset while a word is held and not yet taken
    rst_v = 1'b1; cycle();
    rst_v = 1'b0; v4 = 4'b0001; d4 = 128'd0; d4[31:0] = 32'hDEAD_BEEF; or4 = 1'b0;
    cycle();
    v4 = 4'b0000;
    cycle();
    chk("mid_held", bus4.out_data, 32'hDEAD_BEEF);
    rst_v = 1'b1;
    cycle();
    rst_v = 1'b0; v4 = 4'hF; seq_data4(32'h10); or4 = 1'b1;
    cycle();
    chk("mid_valid", {31'd0, bus4.out_valid}, 32'd0);
    chk("mid_rdy", {28'd0, bus4.in_ready}, 32'h1);
    cycle();
    chk("mid_restart", 32'(bus4.out_sel), 32'd0);

    // randomised traffic on both instances
    for (int c = 0; c < 400; c++) begin
      rst_v = ($urandom_range(0, 49) == 0);
      v4    = 4'($urandom);
      v3    = 3'($urandom);
      or4   = ($urandom_range(0, 3) != 0);
      or3   = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < 4; i++) d4[i*32 +: 32] = $urandom;
      for (int i = 0; i < 3; i++) d3[i*32 +: 32] = $urandom;
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
